// File: rtl/bsg_fifo_rolly_spec_issue.sv
// rtl/bsg_fifo_rolly_spec_issue.sv - speculative issue stage for a rollback-capable 1r1w FIFO
module bsg_fifo_rolly_spec_issue #(
    parameter int width_p        = 32,
    parameter int max_inflight_p = 8,
    localparam int inflight_width_lp = (max_inflight_p + 1 > 1) ? $clog2(max_inflight_p + 1) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [width_p-1:0]           fifo_data_i,
    input  logic                         fifo_v_i,
    output logic                         fifo_yumi_o,
    output logic                         fifo_deq_v_o,
    output logic                         fifo_roll_v_o,
    output logic [width_p-1:0]           data_o,
    output logic                         v_o,
    input  logic                         ready_i,
    input  logic                         commit_v_i,
    input  logic                         squash_v_i,
    output logic [inflight_width_lp-1:0] inflight_o,
    output logic                         commit_err_o,
    output logic [15:0]                  squash_cnt_o
);

    localparam logic [inflight_width_lp-1:0] max_lp = inflight_width_lp'(max_inflight_p);

    logic                         v_r;
    logic [width_p-1:0]           data_r;
    logic [inflight_width_lp-1:0] inflight_r;
    logic [inflight_width_lp-1:0] issued_r;
    logic                         commit_err_r;
    logic [15:0]                  squash_cnt_r;

    logic deq_raw, slot_free, yumi_raw, handshake;

    assign deq_raw   = commit_v_i & (issued_r != '0);
    // A commit this cycle frees a slot, so a full stage can still read.
    assign slot_free = (inflight_r < max_lp) | deq_raw;
    assign yumi_raw  = fifo_v_i & ~squash_v_i & (~v_r | ready_i) & slot_free;
    assign handshake = v_r & ready_i;

    assign fifo_yumi_o   = yumi_raw & reset_n_i;
    assign fifo_deq_v_o  = deq_raw & reset_n_i;
    assign fifo_roll_v_o = squash_v_i & reset_n_i;

    assign v_o          = v_r;
    assign data_o       = data_r;
    assign inflight_o   = inflight_r;
    assign commit_err_o = commit_err_r;
    assign squash_cnt_o = squash_cnt_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_r          <= 1'b0;
            data_r       <= '0;
            inflight_r   <= '0;
            issued_r     <= '0;
            commit_err_r <= 1'b0;
            squash_cnt_r <= '0;
        end else begin
            if (commit_v_i && issued_r == '0)
                commit_err_r <= 1'b1;

            if (squash_v_i) begin
                // Everything uncommitted is dropped; the FIFO replays it after the roll.
                v_r        <= 1'b0;
                inflight_r <= '0;
                issued_r   <= '0;
                if (squash_cnt_r != 16'hFFFF)
                    squash_cnt_r <= squash_cnt_r + 16'd1;
            end else begin
                if (yumi_raw) begin
                    data_r <= fifo_data_i;
                    v_r    <= 1'b1;
                end else if (handshake) begin
                    v_r <= 1'b0;
                end
                inflight_r <= inflight_r + inflight_width_lp'(yumi_raw)
                                         - inflight_width_lp'(deq_raw);
                issued_r   <= issued_r + inflight_width_lp'(handshake)
                                       - inflight_width_lp'(deq_raw);
            end
        end
    end

endmodule

// File: tb/tb_bsg_fifo_rolly_spec_issue.sv
// tb/tb_bsg_fifo_rolly_spec_issue.sv - bench for bsg_fifo_rolly_spec_issue with a rollback FIFO model
module tb_bsg_fifo_rolly_spec_issue;

    localparam int W  = 8;
    localparam int M  = 3;
    localparam int IW = $clog2(M + 1);

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  fifo_data;
    logic          fifo_v;
    logic          fifo_yumi, fifo_deq_v, fifo_roll_v;
    logic [W-1:0]  data;
    logic          v;
    logic          ready, commit_v, squash_v;
    logic [IW-1:0] inflight;
    logic          commit_err;
    logic [15:0]   squash_cnt;

    always #5 clk = ~clk;

    bsg_fifo_rolly_spec_issue #(.width_p(W), .max_inflight_p(M)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .fifo_data_i(fifo_data), .fifo_v_i(fifo_v), .fifo_yumi_o(fifo_yumi),
        .fifo_deq_v_o(fifo_deq_v), .fifo_roll_v_o(fifo_roll_v),
        .data_o(data), .v_o(v), .ready_i(ready),
        .commit_v_i(commit_v), .squash_v_i(squash_v),
        .inflight_o(inflight), .commit_err_o(commit_err), .squash_cnt_o(squash_cnt)
    );

    // Rollback FIFO model: head = committed, rd = speculative read pointer, wr = tail.
    logic [W-1:0] mem [64];
    int head, rd, wr;
    assign fifo_v    = (rd != wr);
    assign fifo_data = mem[rd & 63];

    logic [W-1:0] sb[$];
    logic [W-1:0] unc[$];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       push;
        logic [7:0] pdata;
        logic       ready, commit, squash;
        logic       yumi, deq, roll, v;
        int         infl;
        logic       err;
        int         sq;
    } vec_t;

    vec_t vecs[27];
    vec_t tail_vecs[2];

    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic p, input logic [7:0] pd, input logic r, input logic c,
                                input logic s, input logic y, input logic d, input logic rl,
                                input logic vv, input int inf, input logic e, input int q);
        vec_t t;
        t.push = p; t.pdata = pd; t.ready = r; t.commit = c; t.squash = s;
        t.yumi = y; t.deq = d; t.roll = rl; t.v = vv; t.infl = inf; t.err = e; t.sq = q;
        return t;
    endfunction

    task automatic run_cycle(input vec_t t, input int idx);
        logic c_yumi, c_deq, c_roll;
        if (t.push) begin
            mem[wr & 63] = t.pdata;
            wr++;
            sb.push_back(t.pdata);
        end
        ready = t.ready; commit_v = t.commit; squash_v = t.squash;
        @(negedge clk);
        chk($sformatf("yumi[%0d]", idx), 32'(fifo_yumi), 32'(t.yumi));
        chk($sformatf("deq[%0d]", idx), 32'(fifo_deq_v), 32'(t.deq));
        chk($sformatf("roll[%0d]", idx), 32'(fifo_roll_v), 32'(t.roll));
        chk($sformatf("v[%0d]", idx), 32'(v), 32'(t.v));
        chk($sformatf("inflight[%0d]", idx), 32'(inflight), t.infl);
        chk($sformatf("commit_err[%0d]", idx), 32'(commit_err), 32'(t.err));
        chk($sformatf("squash_cnt[%0d]", idx), 32'(squash_cnt), t.sq);
        if (prev_stall && v)
            chk($sformatf("hold[%0d]", idx), 32'(data), 32'(prev_data));
        prev_stall = v & ~ready;
        prev_data  = data;
        if (commit_v && unc.size() > 0)
            void'(unc.pop_front());
        if (v && ready) begin
            if (sb.size() == 0) begin
                chk($sformatf("unexpected_issue[%0d]", idx), 32'(data), 32'hFFFF_FFFF);
            end else begin
                logic [W-1:0] e;
                e = sb.pop_front();
                chk($sformatf("issue_data[%0d]", idx), 32'(data), 32'(e));
                unc.push_back(e);
            end
        end
        if (squash_v) begin
            for (int i = unc.size() - 1; i >= 0; i--)
                sb.push_front(unc[i]);
            unc.delete();
        end
        c_yumi = fifo_yumi; c_deq = fifo_deq_v; c_roll = fifo_roll_v;
        @(posedge clk);
        #1;
        if (c_deq)  head++;
        if (c_yumi) rd++;
        if (c_roll) rd = head;
    endtask

    initial begin
        // Streaming, limit at 3 in flight, backpressure, squash replay, commit+squash, commit error.
        vecs[0]  = mk(1, 8'hA1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 8'hB2, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        vecs[2]  = mk(1, 8'hC3, 1, 0, 0, 1, 0, 0, 1, 2, 0, 0);
        vecs[3]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        vecs[4]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        vecs[5]  = mk(1, 8'hD4, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        vecs[6]  = mk(1, 8'hE5, 1, 1, 0, 1, 1, 0, 0, 3, 0, 0);
        vecs[7]  = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        vecs[8]  = mk(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 3, 0, 0);
        vecs[9]  = mk(1, 8'hF6, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        vecs[10] = mk(0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 3, 0, 0);
        vecs[11] = mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0);
        vecs[12] = mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 2, 0, 0);
        vecs[13] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        vecs[14] = mk(0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 3, 0, 0);
        vecs[15] = mk(0, 8'h00, 1, 0, 1, 0, 0, 1, 0, 2, 0, 0);
        vecs[16] = mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[17] = mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 1, 0, 1);
        vecs[18] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 2, 0, 1);
        vecs[19] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 2, 0, 1);
        vecs[20] = mk(0, 8'h00, 1, 1, 1, 0, 1, 1, 0, 2, 0, 1);
        vecs[21] = mk(0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2);
        vecs[22] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 1, 1, 0, 2);
        vecs[23] = mk(0, 8'h00, 1, 1, 0, 0, 1, 0, 0, 1, 0, 2);
        vecs[24] = mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2);
        vecs[25] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        vecs[26] = mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        tail_vecs[0] = mk(1, 8'h77, 0, 0, 0, 1, 0, 0, 0, 0, 1, 2);
        tail_vecs[1] = mk(1, 8'h88, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2);

        // Reset with every request input active and a stray entry visible at the FIFO head.
        reset_n = 1'b0; ready = 1'b1; commit_v = 1'b1; squash_v = 1'b1;
        head = 0; rd = 0; wr = 1; mem[0] = 8'h5A;
        #23;
        chk("rst_yumi", 32'(fifo_yumi), 32'd0);
        chk("rst_deq", 32'(fifo_deq_v), 32'd0);
        chk("rst_roll", 32'(fifo_roll_v), 32'd0);
        chk("rst_v", 32'(v), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err", 32'(commit_err), 32'd0);
        chk("rst_sqcnt", 32'(squash_cnt), 32'd0);
        wr = 0; commit_v = 1'b0; squash_v = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 27; i++)
            run_cycle(vecs[i], i);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("unc_drained", 32'(unc.size()), 32'd0);

        // Asynchronous reset while an entry is held and requests are active.
        run_cycle(tail_vecs[0], 100);
        run_cycle(tail_vecs[1], 101);
        #2;
        ready = 1'b1; commit_v = 1'b1; squash_v = 1'b1;
        chk("pre_async_v", 32'(v), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_v", 32'(v), 32'd0);
        chk("async_data", 32'(data), 32'd0);
        chk("async_yumi", 32'(fifo_yumi), 32'd0);
        chk("async_deq", 32'(fifo_deq_v), 32'd0);
        chk("async_roll", 32'(fifo_roll_v), 32'd0);
        chk("async_inflight", 32'(inflight), 32'd0);
        chk("async_err", 32'(commit_err), 32'd0);
        chk("async_sqcnt", 32'(squash_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_fifo_rolly_spec_issue.md
Name: bsg_fifo_rolly_spec_issue

Overview:
- Consumer stage directly downstream of the rollback-capable 1r1w FIFO.
- Reads entries speculatively through the FIFO's yumi interface, registers each one, and issues it to a ready/valid consumer.
- Counts read-but-uncommitted entries. Converts in-order commit events into FIFO dequeue pulses and squash events into FIFO roll pulses, so the FIFO replays every uncommitted entry.

Parameters:
- width_p, (none, required), entry data width.
- max_inflight_p, 8, maximum entries read from the FIFO and not yet committed. Must be at least 1 and at most the FIFO els_p.
- inflight_width_lp, localparam `BSG_SAFE_CLOG2(max_inflight_p+1), width of the in-flight counters.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- fifo_data_i  in  width_p  head entry data from the FIFO, valid in the same cycle.
- fifo_v_i  in  1  FIFO head valid.
- fifo_yumi_o  out  1  speculative read of the FIFO head.
- fifo_deq_v_o  out  1  commits the oldest read entry in the FIFO.
- fifo_roll_v_o  out  1  rewinds the FIFO read pointer to its checkpoint.
- data_o  out  width_p  issued entry.
- v_o  out  1  issued entry valid.
- ready_i  in  1  consumer ready (ready-and-valid handshake).
- commit_v_i  in  1  the oldest issued entry retires.
- squash_v_i  in  1  discard all uncommitted entries and replay them.
- inflight_o  out  inflight_width_lp  current in-flight count.
- commit_err_o  out  1  sticky flag: a commit arrived with nothing issued.
- squash_cnt_o  out  16  saturating count of squashes.

Behaviour:
- State:
  - Output register v_r/data_r.
  - inflight_r: entries read from the FIFO and not committed. This includes the entry held in the output register.
  - issued_r: entries handed to the consumer and not committed. issued_r = inflight_r - v_r always holds.
  - commit_err_r; squash_cnt_r.
- Reset: while reset_n_i is low, all registers are 0 and every output is 0. This includes the combinational fifo_yumi_o, fifo_deq_v_o and fifo_roll_v_o, which are gated by reset_n_i. On reset release the block is idle with no bubble.
- Read:
  - fifo_yumi_o = fifo_v_i & ~squash_v_i & (~v_r | ready_i) & (inflight_r < max_inflight_p, or a commit this cycle frees a slot).
  - On fifo_yumi_o, data_r <= fifo_data_i and v_r <= 1 on the next edge.
  - FIFO-to-v_o latency is 1 cycle. Back-to-back reads sustain 1 entry/cycle while ready_i is high.
- Issue:
  - v_o = v_r, data_o = data_r.
  - When v_o & ready_i and there is no new read, v_r <= 0.
  - data_o must stay stable while v_o is high and ready_i is low.
- Commit:
  - fifo_deq_v_o = commit_v_i & (issued_r != 0).
  - Each such commit decrements inflight_r and issued_r by 1.
  - commit_v_i with issued_r == 0 is ignored, sets commit_err_o, and generates no deq.
- Counter updates per cycle:
  - inflight_r += yumi - deq.
  - issued_r += handshake - deq.
  - Simultaneous read and commit leave inflight_r unchanged.
- Squash:
  - fifo_roll_v_o = squash_v_i, in the same cycle.
  - On the next edge: v_r <= 0, inflight_r <= 0, issued_r <= 0, squash_cnt_r increments, saturating at 0xFFFF.
  - A commit in the same cycle as a squash still asserts fifo_deq_v_o; the FIFO applies the deq together with the roll.
  - A squash suppresses fifo_yumi_o.
  - v_o may be high in the squash cycle. A handshake in that cycle is still counted as issued, then discarded by the clear.
  - The cycle after a squash, the FIFO presents the replayed head and reading resumes normally.
- Full: with inflight_r == max_inflight_p and no commit, fifo_yumi_o stays 0 regardless of fifo_v_i.
- Empty: with fifo_v_i low, no read occurs; v_o drains on the next handshake.
- Reset mid-operation clears all state immediately (asynchronous). The FIFO's own reset is expected to be applied at the same time.
- inflight_o = inflight_r.

Test Plan:
- Streaming:
  - Stimulus: FIFO holds A,B,C; ready_i=1; no commits.
  - Response: yumi for 3 cycles; v_o shows A,B,C on cycles 1-3; inflight_o ends at 3; no deq.
- Limit:
  - Stimulus: max_inflight_p=2; 4 entries; ready_i=1.
  - Response: 2 reads, then yumi=0 with inflight_o=2. A commit_v_i pulse gives deq=1, a yumi in the same cycle, and inflight_o stays 2.
- Backpressure:
  - Stimulus: ready_i=0 with v_o=1.
  - Response: data_o stable, yumi=0. ready_i rises → handshake, and the next entry follows 1 cycle later.
- Squash replay:
  - Stimulus: issue A,B; commit A; squash.
  - Response: roll=1 in the squash cycle; inflight_o=0 the next cycle; B is reissued first; squash_cnt_o=1.
- Commit and squash together:
  - Stimulus: issued A,B; commit_v_i and squash_v_i in the same cycle.
  - Response: deq=1 and roll=1 together; B is replayed next.
- Error and reset:
  - Stimulus: commit_v_i with issued_r=0.
  - Response: deq=0 and commit_err_o=1, sticky. Asserting reset_n_i low mid-stream drops all outputs to 0 without waiting for a clock edge.
